// File: rtl/clock_display_scan.sv
// Multiplexed HH:MM 7-segment driver: snapshots the binary time once per frame,
// converts to BCD and scans four digits with a blanking gap before each drive.
module clock_display_scan #(
    parameter int SCAN_DIV  = 4,
    parameter int BLANK_CYC = 1,
    parameter int LZ_BLANK  = 0
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic [5:0] hour,
    input  logic [6:0] min,
    input  logic       en,
    output logic [3:0] an,
    output logic [6:0] seg,
    output logic       dp,
    output logic       err,
    output logic       frame_done
);

    localparam int CW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYC - 1);
    localparam logic [CW-1:0] DRIVE_PEN  = CW'(SCAN_DIV - 2);
    localparam logic [CW-1:0] SLOT_LAST  = CW'(SCAN_DIV - 1);

    typedef enum logic [1:0] {
        IDLE,
        BLANK,
        DRIVE
    } state_t;

    state_t          state_reg;
    logic [CW-1:0]   cnt_reg;
    logic [1:0]      digit_reg;
    logic [5:0]      snap_hour_reg;
    logic [6:0]      snap_min_reg;

    function automatic logic [6:0] seg_code(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'd0:    s = 7'h3F;
            4'd1:    s = 7'h06;
            4'd2:    s = 7'h5B;
            4'd3:    s = 7'h4F;
            4'd4:    s = 7'h66;
            4'd5:    s = 7'h6D;
            4'd6:    s = 7'h7D;
            4'd7:    s = 7'h07;
            4'd8:    s = 7'h7F;
            4'd9:    s = 7'h6F;
            default: s = 7'h00;
        endcase
        return s;
    endfunction

    function automatic logic out_of_range(input logic [5:0] h, input logic [6:0] m);
        return (h > 6'd23) || (m > 7'd59);
    endfunction

    // Returns {an, seg, dp} for a driven cycle of digit d; a bad snapshot shows dashes
    // everywhere and takes precedence over leading-zero suppression.
    function automatic logic [11:0] slot_out(input logic [1:0] d, input logic [5:0] h,
                                             input logic [6:0] m);
        logic       bad;
        logic [3:0] h_tens;
        logic [3:0] val;
        logic [3:0] an_v;
        logic [6:0] seg_v;
        logic       dp_v;
        bad    = out_of_range(h, m);
        h_tens = 4'(h / 6'd10);
        case (d)
            2'd3:    val = h_tens;
            2'd2:    val = 4'(h % 6'd10);
            2'd1:    val = 4'(m / 7'd10);
            default: val = 4'(m % 7'd10);
        endcase
        an_v  = 4'b0001 << d;
        seg_v = bad ? 7'h40 : seg_code(val);
        dp_v  = (d == 2'd2) && !bad;
        if (LZ_BLANK != 0 && d == 2'd3 && h_tens == 4'd0 && !bad) begin
            an_v  = 4'd0;
            seg_v = 7'd0;
        end
        return {an_v, seg_v, dp_v};
    endfunction

    // Outputs are loaded with the values belonging to the state being entered,
    // so each visible cycle reflects the FSM position of that same cycle.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_reg     <= IDLE;
            cnt_reg       <= '0;
            digit_reg     <= 2'd3;
            snap_hour_reg <= 6'd0;
            snap_min_reg  <= 7'd0;
            {an, seg, dp} <= 12'd0;
            err           <= 1'b0;
            frame_done    <= 1'b0;
        end else if (!en) begin
            state_reg     <= IDLE;
            cnt_reg       <= '0;
            digit_reg     <= 2'd3;
            {an, seg, dp} <= 12'd0;
            err           <= 1'b0;
            frame_done    <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    state_reg     <= BLANK;
                    cnt_reg       <= '0;
                    digit_reg     <= 2'd3;
                    snap_hour_reg <= hour;
                    snap_min_reg  <= min;
                    err           <= out_of_range(hour, min);
                    {an, seg, dp} <= 12'd0;
                    frame_done    <= 1'b0;
                end
                BLANK: begin
                    cnt_reg <= cnt_reg + CW'(1);
                    if (cnt_reg == BLANK_LAST) begin
                        state_reg     <= DRIVE;
                        {an, seg, dp} <= slot_out(digit_reg, snap_hour_reg, snap_min_reg);
                        frame_done    <= (digit_reg == 2'd0) && (cnt_reg == DRIVE_PEN);
                    end else begin
                        {an, seg, dp} <= 12'd0;
                        frame_done    <= 1'b0;
                    end
                end
                DRIVE: begin
                    if (cnt_reg == SLOT_LAST) begin
                        state_reg     <= BLANK;
                        cnt_reg       <= '0;
                        {an, seg, dp} <= 12'd0;
                        frame_done    <= 1'b0;
                        if (digit_reg == 2'd0) begin
                            digit_reg     <= 2'd3;
                            snap_hour_reg <= hour;
                            snap_min_reg  <= min;
                            err           <= out_of_range(hour, min);
                        end else begin
                            digit_reg <= digit_reg - 2'd1;
                        end
                    end else begin
                        cnt_reg       <= cnt_reg + CW'(1);
                        {an, seg, dp} <= slot_out(digit_reg, snap_hour_reg, snap_min_reg);
                        frame_done    <= (digit_reg == 2'd0) && (cnt_reg == DRIVE_PEN);
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule
